// File: rtl/level_speed_scheduler_pkg.sv
// Shared types and terminal-count tables for the Frogger speed scheduler.
// LEVEL_SCHEDULER_TESTSPEED_EN selects short simulation counts in tc_for_level.
package frogger_speed_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    ADVANCE = 3'd3,
    WIN     = 3'd4
  } sched_state_t;

  localparam logic [2:0] LEVEL_1 = 3'b001;
  localparam logic [2:0] LEVEL_2 = 3'b010;
  localparam logic [2:0] LEVEL_3 = 3'b011;
  localparam logic [2:0] LEVEL_4 = 3'b100;

  localparam int TC_WIDTH = 27;

  localparam logic [TC_WIDTH-1:0] TC_PROD [4] = '{
    27'h0FFFFFF, 27'h0DF5E10, 27'h0BEBC1F, 27'h07FFFFF
  };
  localparam logic [TC_WIDTH-1:0] TC_TEST [4] = '{
    27'd15, 27'd11, 27'd7, 27'd3
  };

  // Unreachable level codes fall back to the level-1 count.
  function automatic logic [TC_WIDTH-1:0] tc_for_level(input logic [2:0] level);
    logic [1:0] idx;
    case (level)
      LEVEL_2: idx = 2'd1;
      LEVEL_3: idx = 2'd2;
      LEVEL_4: idx = 2'd3;
      default: idx = 2'd0;
    endcase
`ifdef LEVEL_SCHEDULER_TESTSPEED_EN
    return TC_TEST[idx];
`else
    return TC_PROD[idx];
`endif
  endfunction

endpackage

// File: rtl/level_speed_scheduler_if.sv
// Control/status bundle between the game controller (master) and the speed scheduler (slave).
// start/levelup/gameover are one-cycle pulses sampled on the clock edge; pause is a level hold.
interface level_speed_scheduler_if #(parameter int SPEED_DATAWIDTH = 27);
  import frogger_speed_pkg::*;

  logic                       CC_LEVELSCHEDULER_start_InHigh;
  logic                       CC_LEVELSCHEDULER_pause_InHigh;
  logic                       CC_LEVELSCHEDULER_levelup_InHigh;
  logic                       CC_LEVELSCHEDULER_gameover_InHigh;
  logic                       CC_LEVELSCHEDULER_tick_OutHigh;
  logic [2:0]                 CC_LEVELSCHEDULER_level_data_OutBUS;
  logic [SPEED_DATAWIDTH-1:0] CC_LEVELSCHEDULER_count_data_OutBUS;
  logic                       CC_LEVELSCHEDULER_running_OutHigh;
  logic                       CC_LEVELSCHEDULER_win_OutHigh;
  sched_state_t               CC_LEVELSCHEDULER_state_dbg_OutBUS;

  modport master (
    output CC_LEVELSCHEDULER_start_InHigh, CC_LEVELSCHEDULER_pause_InHigh,
           CC_LEVELSCHEDULER_levelup_InHigh, CC_LEVELSCHEDULER_gameover_InHigh,
    input  CC_LEVELSCHEDULER_tick_OutHigh, CC_LEVELSCHEDULER_level_data_OutBUS,
           CC_LEVELSCHEDULER_count_data_OutBUS, CC_LEVELSCHEDULER_running_OutHigh,
           CC_LEVELSCHEDULER_win_OutHigh, CC_LEVELSCHEDULER_state_dbg_OutBUS
  );

  modport slave (
    input  CC_LEVELSCHEDULER_start_InHigh, CC_LEVELSCHEDULER_pause_InHigh,
           CC_LEVELSCHEDULER_levelup_InHigh, CC_LEVELSCHEDULER_gameover_InHigh,
    output CC_LEVELSCHEDULER_tick_OutHigh, CC_LEVELSCHEDULER_level_data_OutBUS,
           CC_LEVELSCHEDULER_count_data_OutBUS, CC_LEVELSCHEDULER_running_OutHigh,
           CC_LEVELSCHEDULER_win_OutHigh, CC_LEVELSCHEDULER_state_dbg_OutBUS
  );
endinterface

// File: rtl/level_speed_scheduler_tick.sv
// Free-running speed counter: wraps at i_tc and raises a registered one-cycle tick
// on the cycle after the wrap. Clear beats enable and kills any tick.
module speed_tick_counter #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_tc,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tick
);
  logic [WIDTH-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_en && (r_cnt == i_tc)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else if (i_en) begin
      r_cnt  <= r_cnt + WIDTH'(1);
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tick = r_tick;
endmodule

// File: rtl/level_speed_scheduler.sv
// Frogger game-speed scheduler: level/state FSM driving speed_tick_counter.
// Build with LEVEL_SCHEDULER_TESTSPEED_EN for short simulation terminal counts.
module level_speed_scheduler
  import frogger_speed_pkg::*;
#(
  parameter int SPEED_DATAWIDTH = 27,
  parameter int MAX_LEVEL       = 4
) (
  input  logic                    CC_LEVELSCHEDULER_CLOCK_50,
  input  logic                    CC_LEVELSCHEDULER_RESET_InLow,
  level_speed_scheduler_if.slave  bus
);
  localparam logic [2:0] L_MAX = 3'(MAX_LEVEL);

  sched_state_t               r_state;
  logic [2:0]                 r_level;
  logic                       r_running;
  logic                       r_win;

  sched_state_t               w_next_state;
  logic [2:0]                 w_next_level;
  logic                       w_clr;
  logic                       w_en;
  logic [SPEED_DATAWIDTH-1:0] w_tc;
  logic [SPEED_DATAWIDTH-1:0] w_cnt;
  logic                       w_tick;

  assign w_tc = SPEED_DATAWIDTH'(tc_for_level(r_level));

  // Priority: gameover > start > levelup > pause. Counting happens only in RUN.
  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    if (bus.CC_LEVELSCHEDULER_gameover_InHigh) begin
      w_next_state = IDLE;
      w_next_level = LEVEL_1;
      w_clr        = 1'b1;
    end else if (bus.CC_LEVELSCHEDULER_start_InHigh) begin
      w_next_state = RUN;
      w_next_level = LEVEL_1;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        RUN, PAUSE: begin
          if (bus.CC_LEVELSCHEDULER_levelup_InHigh) begin
            w_clr        = 1'b1;
            w_next_state = (r_level < L_MAX) ? ADVANCE : WIN;
          end else if (bus.CC_LEVELSCHEDULER_pause_InHigh) begin
            w_next_state = PAUSE;
          end else begin
            w_next_state = RUN;
            w_en         = (r_state == RUN);
          end
        end
        ADVANCE: begin
          w_clr        = 1'b1;
          w_next_level = r_level + 3'd1;
          w_next_state = bus.CC_LEVELSCHEDULER_pause_InHigh ? PAUSE : RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CC_LEVELSCHEDULER_CLOCK_50 or negedge CC_LEVELSCHEDULER_RESET_InLow) begin
    if (!CC_LEVELSCHEDULER_RESET_InLow) begin
      r_state   <= IDLE;
      r_level   <= LEVEL_1;
      r_running <= 1'b0;
      r_win     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_level   <= w_next_level;
      r_running <= (w_next_state == RUN);
      r_win     <= (w_next_state == WIN);
    end
  end

  speed_tick_counter #(.WIDTH(SPEED_DATAWIDTH)) u_counter (
    .clk    (CC_LEVELSCHEDULER_CLOCK_50),
    .rst_n  (CC_LEVELSCHEDULER_RESET_InLow),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_tc   (w_tc),
    .o_cnt  (w_cnt),
    .o_tick (w_tick)
  );

  assign bus.CC_LEVELSCHEDULER_tick_OutHigh      = w_tick;
  assign bus.CC_LEVELSCHEDULER_level_data_OutBUS = r_level;
  assign bus.CC_LEVELSCHEDULER_count_data_OutBUS = w_cnt;
  assign bus.CC_LEVELSCHEDULER_running_OutHigh   = r_running;
  assign bus.CC_LEVELSCHEDULER_win_OutHigh       = r_win;
  assign bus.CC_LEVELSCHEDULER_state_dbg_OutBUS  = r_state;
endmodule

// File: tb/tb_level_speed_scheduler.sv
// Self-checking bench for level_speed_scheduler: cycle model feeding an expected queue,
// plus scenario tasks for start, level-up, pause, win, collisions and mid-game reset.
module tb_level_speed_scheduler;
  import frogger_speed_pkg::*;

  // Narrow counter so the production table (truncated to W bits) ticks within a short run.
  localparam int W  = 8;
  localparam int EW = 3 + 3 + W + 3;

`ifdef LEVEL_SCHEDULER_TESTSPEED_EN
  localparam logic [26:0] TB_TC [4] = '{27'd15, 27'd11, 27'd7, 27'd3};
`else
  localparam logic [26:0] TB_TC [4] = '{27'h0FFFFFF, 27'h0DF5E10, 27'h0BEBC1F, 27'h07FFFFF};
`endif

  function automatic logic [W-1:0] tcl(input int lvl);
    logic [26:0] full;
    full = TB_TC[lvl-1];
    return full[W-1:0];
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, pause = 1'b0, levelup = 1'b0, gameover = 1'b0;

  level_speed_scheduler_if #(.SPEED_DATAWIDTH(W)) bus ();

  assign bus.CC_LEVELSCHEDULER_start_InHigh    = start;
  assign bus.CC_LEVELSCHEDULER_pause_InHigh    = pause;
  assign bus.CC_LEVELSCHEDULER_levelup_InHigh  = levelup;
  assign bus.CC_LEVELSCHEDULER_gameover_InHigh = gameover;

  level_speed_scheduler #(.SPEED_DATAWIDTH(W), .MAX_LEVEL(4)) dut (
    .CC_LEVELSCHEDULER_CLOCK_50    (clk),
    .CC_LEVELSCHEDULER_RESET_InLow (rst_n),
    .bus                           (bus)
  );

  logic         tick, running, win;
  logic [2:0]   level;
  logic [W-1:0] cnt;
  sched_state_t state;
  assign tick    = bus.CC_LEVELSCHEDULER_tick_OutHigh;
  assign running = bus.CC_LEVELSCHEDULER_running_OutHigh;
  assign win     = bus.CC_LEVELSCHEDULER_win_OutHigh;
  assign level   = bus.CC_LEVELSCHEDULER_level_data_OutBUS;
  assign cnt     = bus.CC_LEVELSCHEDULER_count_data_OutBUS;
  assign state   = bus.CC_LEVELSCHEDULER_state_dbg_OutBUS;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  sched_state_t  m_st;
  int            m_lvl;
  logic [W-1:0]  m_cnt;
  logic          m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = IDLE; m_lvl = 1; m_cnt = '0; m_tick = 1'b0;
      exp_q.delete();
    end else begin
      m_tick = 1'b0;
      if (gameover) begin
        m_st = IDLE; m_lvl = 1; m_cnt = '0;
      end else if (start) begin
        m_st = RUN; m_lvl = 1; m_cnt = '0;
      end else begin
        case (m_st)
          RUN, PAUSE: begin
            if (levelup) begin
              m_cnt = '0;
              m_st  = (m_lvl < 4) ? ADVANCE : WIN;
            end else if (pause) m_st = PAUSE;
            else if (m_st == PAUSE) m_st = RUN;
            else if (m_cnt == tcl(m_lvl)) begin
              m_cnt = '0; m_tick = 1'b1;
            end else m_cnt = m_cnt + 1'b1;
          end
          ADVANCE: begin
            m_lvl = m_lvl + 1; m_cnt = '0;
            m_st  = pause ? PAUSE : RUN;
          end
          default: ;
        endcase
      end
      exp_q.push_back({m_tick, (m_st == RUN), (m_st == WIN), 3'(m_lvl), m_cnt, m_st});
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tick, running, win, level, cnt, state};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL scoreboard t=%0t actual={tick,run,win,lvl,cnt,st}=%h expected=%h", $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int tick_pos[$];

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_levelup();
    levelup = 1'b1; @(negedge clk); levelup = 1'b0;
  endtask

  task automatic watch(input int n);
    tick_pos.delete();
    for (int j = 0; j <= n; j++) begin
      if (tick === 1'b1) tick_pos.push_back(j);
      if (j < n) @(negedge clk);
    end
  endtask

  task automatic wait_cnt(input logic [W-1:0] v, input string nm);
    int n = 0;
    while (cnt !== v && n < 1000) begin @(negedge clk); n++; end
    n_cmp++;
    if (cnt !== v) begin
      n_err++;
      $display("FAIL %s_timeout actual cnt=%0d required=%0d", nm, cnt, v);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tick, running, win} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags actual=%b required=000", {tick, running, win});
    end
    n_cmp++;
    if (level !== 3'b001 || cnt !== '0 || state !== IDLE) begin
      n_err++; $display("FAIL reset_regs actual lvl=%0d cnt=%0d st=%0d required 1/0/IDLE", level, cnt, state);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (state !== IDLE || tick !== 1'b0 || cnt !== '0) begin
      n_err++; $display("FAIL idle_hold actual st=%0d tick=%b cnt=%0d required IDLE/0/0", state, tick, cnt);
    end
  endtask

  task automatic test_start_ticks();
    int p = int'(tcl(1)) + 1;
    pulse_start();
    n_cmp++;
    if (running !== 1'b1 || level !== 3'b001 || cnt !== '0) begin
      n_err++; $display("FAIL start_state actual run=%b lvl=%0d cnt=%0d required 1/1/0", running, level, cnt);
    end
    watch(3 * p + 1);
    n_cmp++;
    if (tick_pos.size() != 3) begin
      n_err++; $display("FAIL start_tick_count actual=%0d required=3", tick_pos.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (tick_pos[i] != (i + 1) * p) begin
          n_err++; $display("FAIL start_tick_pos%0d actual=%0d required=%0d", i, tick_pos[i], (i + 1) * p);
        end
      end
    end
  endtask

  task automatic test_levelup();
    int p = int'(tcl(2)) + 1;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    pulse_levelup();
    n_cmp++;
    if (state !== ADVANCE || cnt !== '0 || tick !== 1'b0) begin
      n_err++; $display("FAIL levelup_advance actual st=%0d cnt=%0d tick=%b required ADVANCE/0/0", state, cnt, tick);
    end
    @(negedge clk);
    n_cmp++;
    if (level !== 3'b010 || cnt !== '0 || state !== RUN) begin
      n_err++; $display("FAIL levelup_l2 actual lvl=%0d cnt=%0d st=%0d required 2/0/RUN", level, cnt, state);
    end
    watch(2 * p);
    n_cmp++;
    if (tick_pos.size() != 2 || tick_pos[0] != p || tick_pos[1] != 2 * p) begin
      n_err++; $display("FAIL levelup_ticks actual n=%0d required ticks at %0d,%0d", tick_pos.size(), p, 2 * p);
    end
  endtask

  task automatic test_pause();
    int tc = int'(tcl(3));
    int bad = 0;
    pulse_levelup();
    @(negedge clk);
    wait_cnt(W'(5), "pause_wait");
    pause = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tick !== 1'b0 || cnt !== W'(5)) bad++;
    end
    n_cmp++;
    if (bad != 0 || state !== PAUSE) begin
      n_err++; $display("FAIL pause_frozen actual bad_cycles=%0d st=%0d required 0/PAUSE", bad, state);
    end
    pause = 1'b0;
    @(negedge clk);
    watch(tc - 3);
    n_cmp++;
    if (tick_pos.size() != 1 || tick_pos[0] != tc - 4) begin
      n_err++; $display("FAIL pause_resume actual n=%0d required one tick %0d cycles after release", tick_pos.size(), tc - 4);
    end
  endtask

  task automatic test_win();
    pulse_levelup();
    @(negedge clk);
    n_cmp++;
    if (level !== 3'b100 || state !== RUN) begin
      n_err++; $display("FAIL win_l4 actual lvl=%0d st=%0d required 4/RUN", level, state);
    end
    pulse_levelup();
    n_cmp++;
    if (win !== 1'b1 || running !== 1'b0 || level !== 3'b100 || cnt !== '0) begin
      n_err++; $display("FAIL win_entry actual win=%b run=%b lvl=%0d cnt=%0d required 1/0/4/0", win, running, level, cnt);
    end
    levelup = 1'b1; pause = 1'b1;
    watch(40);
    levelup = 1'b0; pause = 1'b0;
    n_cmp++;
    if (tick_pos.size() != 0 || win !== 1'b1 || level !== 3'b100) begin
      n_err++; $display("FAIL win_hold actual ticks=%0d win=%b lvl=%0d required 0/1/4", tick_pos.size(), win, level);
    end
    pulse_start();
    n_cmp++;
    if (running !== 1'b1 || win !== 1'b0 || level !== 3'b001) begin
      n_err++; $display("FAIL win_restart actual run=%b win=%b lvl=%0d required 1/0/1", running, win, level);
    end
  endtask

  task automatic test_levelup_at_tc();
    pulse_levelup();
    @(negedge clk);
    wait_cnt(tcl(2), "lu_tc_wait");
    pulse_levelup();
    n_cmp++;
    if (tick !== 1'b0 || state !== ADVANCE || cnt !== '0) begin
      n_err++; $display("FAIL lu_at_tc_adv actual tick=%b st=%0d cnt=%0d required 0/ADVANCE/0", tick, state, cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (tick !== 1'b0 || level !== 3'b011 || cnt !== '0) begin
      n_err++; $display("FAIL lu_at_tc_l3 actual tick=%b lvl=%0d cnt=%0d required 0/3/0", tick, level, cnt);
    end
  endtask

  task automatic test_gameover_levelup();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    gameover = 1'b1; levelup = 1'b1;
    @(negedge clk);
    gameover = 1'b0; levelup = 1'b0;
    n_cmp++;
    if (state !== IDLE || level !== 3'b001 || running !== 1'b0 || cnt !== '0 || tick !== 1'b0) begin
      n_err++; $display("FAIL go_lu actual st=%0d lvl=%0d run=%b cnt=%0d required IDLE/1/0/0", state, level, running, cnt);
    end
    pulse_levelup();
    n_cmp++;
    if (state !== IDLE || level !== 3'b001) begin
      n_err++; $display("FAIL idle_levelup actual st=%0d lvl=%0d required IDLE/1", state, level);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    pulse_levelup();
    @(negedge clk);
    pulse_levelup();
    @(negedge clk);
    wait_cnt(tcl(3), "rst_mid_wait");
    @(posedge clk);
    #1;
    n_cmp++;
    if (tick !== 1'b1 || level !== 3'b011) begin
      n_err++; $display("FAIL rst_mid_pre actual tick=%b lvl=%0d required 1/3", tick, level);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tick, running, win} !== 3'b000 || level !== 3'b001 || cnt !== '0) begin
      n_err++; $display("FAIL rst_mid_async actual flags=%b lvl=%0d cnt=%0d required 000/1/0", {tick, running, win}, level, cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(2 * (int'(tcl(3)) + 1));
    n_cmp++;
    if (tick_pos.size() != 0 || state !== IDLE) begin
      n_err++; $display("FAIL rst_mid_idle actual ticks=%0d st=%0d required 0/IDLE", tick_pos.size(), state);
    end
    pulse_start();
    n_cmp++;
    if (running !== 1'b1 || level !== 3'b001) begin
      n_err++; $display("FAIL rst_mid_restart actual run=%b lvl=%0d required 1/1", running, level);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_ticks();
    test_levelup();
    test_pause();
    test_win();
    test_levelup_at_tc();
    test_gameover_levelup();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
